// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 stream sequencer and its neighbours.
//   seq_state_e : sequencer FSM states
//   PAD_BYTE    : first byte of MD5 padding
//   IV_A..IV_D  : MD5 initial chaining values; IV packs them as {A,B,C,D}
package md5_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      FILL,
      PAD,
      LOAD,
      WAIT_CORE
   } seq_state_e;

   localparam logic [7:0]   PAD_BYTE = 8'h80;

   localparam logic [31:0]  IV_A = 32'h67452301;
   localparam logic [31:0]  IV_B = 32'hEFCDAB89;
   localparam logic [31:0]  IV_C = 32'h98BADCFE;
   localparam logic [31:0]  IV_D = 32'h10325476;
   localparam logic [127:0] IV   = {IV_A, IV_B, IV_C, IV_D};

endpackage

// File: rtl/md5_stream_sequencer_if.sv
// Message word stream into the MD5 sequencer.
//   s_valid_i : source holds a word
//   s_ready_o : sequencer takes the word this cycle
//   s_data_i  : message word, byte 0 in bits 7:0
//   s_last_i  : final word of the message
//   s_bytes_i : valid bytes minus 1 in the final word
// Handshake: a word transfers on every rising clk edge where s_valid_i and
// s_ready_o are both high. Once s_valid_i is raised the source keeps it and
// s_data_i/s_last_i/s_bytes_i stable until that transfer happens. s_ready_o
// may depend combinationally on s_valid_i.
interface md5_stream_sequencer_if;

   logic        s_valid_i;
   logic        s_ready_o;
   logic [31:0] s_data_i;
   logic        s_last_i;
   logic [1:0]  s_bytes_i;

   modport master (output s_valid_i, output s_data_i, output s_last_i,
                   output s_bytes_i, input s_ready_o);

   modport slave  (input s_valid_i, input s_data_i, input s_last_i,
                   input s_bytes_i, output s_ready_o);

endinterface

// File: rtl/md5_pad_word.sv
// Last-word masking for MD5 padding.
//   data_i  : incoming message word
//   last_i  : word is the final one of the message
//   bytes_i : valid bytes minus 1 (only meaningful with last_i)
//   word_o  : word with bytes past the message zeroed and 0x80 appended
//   carry_o : the word was full, so 0x80 belongs in byte 0 of the next word
module md5_pad_word
   import md5_pkg::*;
(
   input  logic [31:0] data_i,
   input  logic        last_i,
   input  logic [1:0]  bytes_i,
   output logic [31:0] word_o,
   output logic        carry_o
);

   always_comb begin
      word_o  = data_i;
      carry_o = 1'b0;
      if (last_i) begin
         case (bytes_i)
            2'd0:    word_o = {16'h0000, PAD_BYTE, data_i[7:0]};
            2'd1:    word_o = {8'h00, PAD_BYTE, data_i[15:0]};
            2'd2:    word_o = {PAD_BYTE, data_i[23:0]};
            default: carry_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/md5_stream_sequencer.sv
// Packs a 32-bit message stream into MD5-padded 512-bit blocks and feeds them
// to an md5 core as four 128-bit loads per block.
//   clk, reset          : clock, synchronous active-high reset
//   s                   : message word stream (slave side)
//   core_newtext_o      : start of a new message for the core
//   core_load_o/data_o  : one 128-bit block quarter per cycle
//   core_ready_i/data_i : core finished a block; {A,B,C,D}
//   digest_o            : final digest, held until the next one
//   digest_valid_o      : one-cycle strobe with a new digest
//   busy_o              : sequencer is outside IDLE
//   error_o             : sticky, core never answered a block
//   dbg_state_o         : current FSM state
module md5_stream_sequencer
   import md5_pkg::*;
#(
   parameter int WAIT_MAX = 255,
   parameter int LEN_W    = 64
)
(
   input  logic                   clk,
   input  logic                   reset,
   md5_stream_sequencer_if.slave  s,
   output logic                   core_newtext_o,
   output logic                   core_load_o,
   output logic [127:0]           core_data_o,
   input  logic                   core_ready_i,
   input  logic [127:0]           core_data_i,
   output logic [127:0]           digest_o,
   output logic                   digest_valid_o,
   output logic                   busy_o,
   output logic                   error_o,
   output seq_state_e             dbg_state_o
);

   localparam int WD_W = $clog2(WAIT_MAX + 1);

   seq_state_e         state;
   logic [511:0]       blk_buf;
   logic [511:0]       pad_buf;
   logic [4:0]         k;          // next free word index, 0..16
   logic [1:0]         ld_idx;
   logic [LEN_W-1:0]   byte_cnt;
   logic [LEN_W-1:0]   byte_inc;
   logic [WD_W-1:0]    wdog;
   logic               pend80;     // 0x80 still owed at word k
   logic               final_blk;  // block in flight carries the length
   logic               extra_blk;  // a zero+length block must follow
   logic [31:0]        in_word;
   logic               in_carry;
   logic [63:0]        len_bits;
   logic               pad_fits;
   logic               fire;

   md5_pad_word u_pad_word (
      .data_i  (s.s_data_i),
      .last_i  (s.s_last_i),
      .bytes_i (s.s_bytes_i),
      .word_o  (in_word),
      .carry_o (in_carry)
   );

   // In IDLE the first valid word only wakes the FSM; it is taken in FILL.
   assign s.s_ready_o = ~reset & ((state == FILL) | ((state == IDLE) & ~s.s_valid_i));
   assign fire        = s.s_valid_i & s.s_ready_o & (state == FILL);
   assign busy_o      = (state != IDLE);
   assign dbg_state_o = state;

   always_comb begin
      byte_inc = s.s_last_i ? (LEN_W'(s.s_bytes_i) + LEN_W'(1)) : LEN_W'(4);
      len_bits = 64'({byte_cnt, 3'b000});
      pad_fits = ({1'b0, k} + {5'b00000, pend80}) <= 6'd14;
   end

   // Zero-fill from word k, drop the owed 0x80 at k, and append the length
   // when words 14/15 are still free after the 0x80 byte.
   always_comb begin
      pad_buf = blk_buf;
      for (int i = 0; i < 16; i++) begin
         if (5'(i) >= k)
            pad_buf[511-32*i -: 32] = (pend80 && (5'(i) == k)) ? {24'h000000, PAD_BYTE} : 32'h0;
      end
      if (pad_fits) begin
         pad_buf[63:32] = len_bits[31:0];
         pad_buf[31:0]  = len_bits[63:32];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         blk_buf        <= '0;
         k              <= '0;
         ld_idx         <= '0;
         byte_cnt       <= '0;
         wdog           <= '0;
         pend80         <= 1'b0;
         final_blk      <= 1'b0;
         extra_blk      <= 1'b0;
         core_newtext_o <= 1'b0;
         core_load_o    <= 1'b0;
         core_data_o    <= '0;
         digest_o       <= '0;
         digest_valid_o <= 1'b0;
         error_o        <= 1'b0;
      end else begin
         core_newtext_o <= 1'b0;
         core_load_o    <= 1'b0;
         digest_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (s.s_valid_i) begin
                  core_newtext_o <= 1'b1;
                  error_o        <= 1'b0;
                  state          <= INIT;
               end
            end
            INIT: begin
               k         <= '0;
               byte_cnt  <= '0;
               pend80    <= 1'b0;
               final_blk <= 1'b0;
               extra_blk <= 1'b0;
               state     <= FILL;
            end
            FILL: begin
               if (fire) begin
                  // word k lives at [511-32k -: 32]
                  blk_buf[{~k[3:0], 5'h1f} -: 32] <= in_word;
                  k        <= k + 5'd1;
                  byte_cnt <= byte_cnt + byte_inc;
                  if (s.s_last_i) begin
                     pend80 <= in_carry;
                     state  <= PAD;
                  end else if (k == 5'd15) begin
                     ld_idx <= '0;
                     state  <= LOAD;
                  end
               end
            end
            PAD: begin
               blk_buf   <= pad_buf;
               // A full block with 0x80 owed carries it into the next block.
               pend80    <= pend80 & (k == 5'd16);
               final_blk <= pad_fits;
               extra_blk <= ~pad_fits;
               ld_idx    <= '0;
               state     <= LOAD;
            end
            LOAD: begin
               core_load_o <= 1'b1;
               core_data_o <= blk_buf[{~ld_idx, 7'h7f} -: 128];
               ld_idx      <= ld_idx + 2'd1;
               if (ld_idx == 2'd3) begin
                  wdog  <= '0;
                  state <= WAIT_CORE;
               end
            end
            WAIT_CORE: begin
               if (core_ready_i) begin
                  if (final_blk) begin
                     digest_o       <= core_data_i;
                     digest_valid_o <= 1'b1;
                     state          <= IDLE;
                  end else begin
                     k         <= '0;
                     extra_blk <= 1'b0;
                     state     <= extra_blk ? PAD : FILL;
                  end
               end else if (wdog == WD_W'(WAIT_MAX - 1)) begin
                  error_o <= 1'b1;
                  state   <= IDLE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md5_stream_sequencer.sv
// Directed bench for md5_stream_sequencer with a behavioural core stand-in.
module tb_md5_stream_sequencer;
   import md5_pkg::*;

   localparam int             RDY_DLY    = 12;
   localparam logic [127:0]   ABC_DIGEST = 128'h98500190b04fd23c7d3f96d6727fe128;

   // clock / reset
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   md5_stream_sequencer_if sif ();
   logic         core_newtext_o, core_load_o, digest_valid_o, busy_o, error_o;
   logic [127:0] core_data_o, digest_o;
   logic         core_ready_i = 1'b0;
   logic [127:0] core_data_i  = '0;
   seq_state_e   dbg_state;

   md5_stream_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .s              (sif),
      .core_newtext_o (core_newtext_o),
      .core_load_o    (core_load_o),
      .core_data_o    (core_data_o),
      .core_ready_i   (core_ready_i),
      .core_data_i    (core_data_i),
      .digest_o       (digest_o),
      .digest_valid_o (digest_valid_o),
      .busy_o         (busy_o),
      .error_o        (error_o),
      .dbg_state_o    (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // toy chaining function standing in for the MD5 compression
   function automatic logic [127:0] fold(input logic [127:0] hv, input logic [511:0] b);
      return {hv[118:0], hv[127:119]} + (b[511:384] ^ {b[319:256], b[383:320]})
             + (b[255:128] ^ b[127:0]);
   endfunction

   function automatic logic [31:0] wd(input logic [511:0] b, input int w);
      return b[511-32*w -: 32];
   endfunction

   // core stand-in: collects loads into blocks and answers after RDY_DLY
   logic [511:0] rx_q[$];
   logic [511:0] cur = '0;
   logic [127:0] h = '0;
   int ld_cnt = 0, rdy_cnt = 0, nt_cnt = 0, load_total = 0, dv_cnt = 0;
   logic core_hang = 1'b0;
   logic abc_mode  = 1'b0;

   always @(posedge clk) begin
      #2;
      if (reset) begin
         core_ready_i = 1'b0;
         ld_cnt       = 0;
         rdy_cnt      = 0;
      end else begin
         core_ready_i = 1'b0;
         if (digest_valid_o) dv_cnt++;
         if (core_newtext_o) begin
            nt_cnt++;
            h = IV;
         end
         if (core_load_o) begin
            cur = {cur[383:0], core_data_o};
            ld_cnt++;
            load_total++;
            if (ld_cnt == 4) begin
               ld_cnt = 0;
               rx_q.push_back(cur);
               h       = fold(h, cur);
               rdy_cnt = RDY_DLY;
            end
         end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0 && !core_hang) begin
               core_ready_i = 1'b1;
               core_data_i  = abc_mode ? ABC_DIGEST : h;
            end
         end
      end
   end

   // scoreboard
   logic [511:0] exp_q[$];
   logic [7:0]   msg[0:127];
   int           rx_base = 0;

   function automatic logic [511:0] rx_blk(input int idx);
      if (idx < rx_q.size()) return rx_q[idx];
      return 'x;
   endfunction

   // byte-level MD5 padding of msg[0..n-1] into expected blocks
   task automatic build_exp(input int n);
      logic [7:0]   p[0:191];
      logic [63:0]  bits;
      logic [511:0] blk;
      int nb;
      nb = (n + 8) / 64 + 1;
      for (int i = 0; i < 192; i++) p[i] = 8'h00;
      for (int i = 0; i < n; i++) p[i] = msg[i];
      p[n] = 8'h80;
      bits = 64'(n) << 3;
      for (int j = 0; j < 8; j++) p[nb*64-8+j] = bits[8*j +: 8];
      exp_q.delete();
      for (int b = 0; b < nb; b++) begin
         blk = '0;
         for (int w = 0; w < 16; w++)
            blk[511-32*w -: 32] = {p[b*64+4*w+3], p[b*64+4*w+2], p[b*64+4*w+1], p[b*64+4*w]};
         exp_q.push_back(blk);
      end
   endtask

   // driver: one word per handshake; unused bytes of the last word are junk
   task automatic send_msg(input int n, output bit ok);
      int nw;
      int guard;
      logic [31:0] d;
      nw = (n + 3) / 4;
      ok = 1'b1;
      for (int w = 0; w < nw; w++) begin
         for (int b = 0; b < 4; b++) d[8*b +: 8] = (4*w + b < n) ? msg[4*w+b] : 8'hEE;
         sif.s_data_i  = d;
         sif.s_valid_i = 1'b1;
         sif.s_last_i  = (w == nw - 1);
         sif.s_bytes_i = (w == nw - 1) ? 2'((n - 1) % 4) : 2'($urandom_range(0, 3));
         #1;
         guard = 0;
         while (!sif.s_ready_o && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
         end
         if (guard >= 2000) begin
            ok = 1'b0;
            break;
         end
         @(negedge clk);
      end
      sif.s_valid_i = 1'b0;
      sif.s_last_i  = 1'b0;
   endtask

   task automatic wait_digest(output bit seen, output logic [127:0] dg);
      seen = 1'b0;
      dg   = '0;
      for (int c = 0; c < 3000; c++) begin
         if (digest_valid_o) begin
            seen = 1'b1;
            dg   = digest_o;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_msg(input int n, input bit use_abc, input string name);
      bit ok, seen;
      logic [127:0] dg, exp_d;
      int nt0;
      rx_base  = rx_q.size();
      nt0      = nt_cnt;
      abc_mode = use_abc;
      build_exp(n);
      send_msg(n, ok);
      chk({name, "_hs"}, 512'(ok), 512'(1));
      chk({name, "_err_clr"}, 512'(error_o), 512'(0));
      wait_digest(seen, dg);
      chk({name, "_dv"}, 512'(seen), 512'(1));
      exp_d = IV;
      foreach (exp_q[i]) exp_d = fold(exp_d, exp_q[i]);
      if (use_abc) exp_d = ABC_DIGEST;
      chk({name, "_digest"}, 512'(dg), 512'(exp_d));
      @(negedge clk);
      chk({name, "_dv_pulse"}, 512'(digest_valid_o), 512'(0));
      chk({name, "_idle"}, 512'(busy_o), 512'(0));
      chk({name, "_hold"}, 512'(digest_o), 512'(exp_d));
      chk({name, "_nblk"}, 512'(rx_q.size() - rx_base), 512'(exp_q.size()));
      foreach (exp_q[i]) chk($sformatf("%s_blk%0d", name, i), rx_blk(rx_base + i), exp_q[i]);
      chk({name, "_newtext"}, 512'(nt_cnt - nt0), 512'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      bit ok;
      int base, dv0, guard;
      sif.s_valid_i = 1'b0;
      sif.s_data_i  = '0;
      sif.s_last_i  = 1'b0;
      sif.s_bytes_i = '0;

      // reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", 512'({core_newtext_o, core_load_o, digest_valid_o, busy_o, error_o, sif.s_ready_o}), 512'(0));
      chk("rst_core_data", 512'(core_data_o), 512'(0));
      chk("rst_digest", 512'(digest_o), 512'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", 512'(sif.s_ready_o), 512'(1));
      chk("idle_state", 512'(dbg_state), 512'(IDLE));

      // "abc"
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      run_msg(3, 1'b1, "abc");
      chk("abc_w0", 512'(wd(rx_blk(rx_base), 0)), 512'(32'h80636261));
      chk("abc_w14", 512'(wd(rx_blk(rx_base), 14)), 512'(32'h18));
      chk("abc_w15", 512'(wd(rx_blk(rx_base), 15)), 512'(0));

      for (int i = 0; i < 128; i++) msg[i] = 8'(i * 13 + 1);

      // 55 bytes: one block
      run_msg(55, 1'b0, "m55");
      chk("m55_w14", 512'(wd(rx_blk(rx_base), 14)), 512'(32'h1B8));

      // 56 bytes: 0x80 in word 14, length in a second block
      run_msg(56, 1'b0, "m56");
      chk("m56_b0_w14", 512'(wd(rx_blk(rx_base), 14)), 512'(32'h80));
      chk("m56_b1_zero", 512'(rx_blk(rx_base + 1) >> 64), 512'(0));
      chk("m56_b1_w14", 512'(wd(rx_blk(rx_base + 1), 14)), 512'(32'h1C0));

      // 64 bytes: full block then {0x80, zeros, length}
      run_msg(64, 1'b0, "m64");
      chk("m64_b1_w0", 512'(wd(rx_blk(rx_base + 1), 0)), 512'(32'h80));
      chk("m64_b1_mid", 512'(rx_blk(rx_base + 1) << 32 >> 96), 512'(0));
      chk("m64_b1_w14", 512'(wd(rx_blk(rx_base + 1), 14)), 512'(32'h200));
      chk("m64_b1_w15", 512'(wd(rx_blk(rx_base + 1), 15)), 512'(0));

      // watchdog
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      core_hang = 1'b1;
      base      = load_total;
      dv0       = dv_cnt;
      send_msg(3, ok);
      chk("wd_hs", 512'(ok), 512'(1));
      guard = 0;
      while (load_total - base < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("wd_loads", 512'(load_total - base), 512'(4));
      repeat (200) @(negedge clk);
      chk("wd_early", 512'(error_o), 512'(0));
      chk("wd_busy", 512'(busy_o), 512'(1));
      guard = 0;
      while (!error_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("wd_err", 512'(error_o), 512'(1));
      repeat (5) @(negedge clk);
      chk("wd_sticky", 512'(error_o), 512'(1));
      chk("wd_idle", 512'(busy_o), 512'(0));
      chk("wd_no_dv", 512'(dv_cnt - dv0), 512'(0));
      core_hang = 1'b0;
      run_msg(3, 1'b1, "abc_after_wd");

      // reset during the third load
      abc_mode = 1'b1;
      base     = load_total;
      dv0      = dv_cnt;
      send_msg(3, ok);
      chk("rl_hs", 512'(ok), 512'(1));
      guard = 0;
      while (load_total - base < 3 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("rl_loads", 512'(load_total - base), 512'(3));
      reset = 1'b1;
      @(negedge clk);
      chk("rl_ctrl", 512'({core_newtext_o, core_load_o, digest_valid_o, busy_o, error_o, sif.s_ready_o}), 512'(0));
      chk("rl_core_data", 512'(core_data_o), 512'(0));
      chk("rl_digest", 512'(digest_o), 512'(0));
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("rl_no_dv", 512'(dv_cnt - dv0), 512'(0));
      chk("rl_idle", 512'(busy_o), 512'(0));
      run_msg(3, 1'b1, "abc_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
